irq_source: RTL and testbench

Interrupt request generator for the pipelined MIPS core's CP0 interrupt inputs.
- Synchronises and debounces three raw board buttons and turns each debounced press into a sticky pending request, driven as level outputs `irq[2:0]` into the CP0 `ir0..ir2` inputs.
- Holds each request until CP0 acknowledges taking that interrupt.
- Exports a priority-encoded request ID and sticky overrun flags for the display/counter logic.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_source_debounce.sv | 46 ++++
 rtl/irq_source.sv | 68 ++++++
 tb/tb_irq_source.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and the request priority encoder used by the interrupt
// request generator.
package irq_pkg;

   localparam int unsigned N_IRQ    = 3;
   localparam int unsigned IRQ_ID_W = 2;
   localparam logic [IRQ_ID_W-1:0] IRQ_ID_NONE = 2'd3;

   // Lowest-numbered pending channel wins; IRQ_ID 0 when nothing is pending.
   function automatic logic [IRQ_ID_W-1:0] prio_enc(input logic [N_IRQ-1:0] req);
      logic [IRQ_ID_W-1:0] id;
      id = '0;
      for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
         if (req[i]) id = IRQ_ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/irq_source_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button input.
module debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter only runs while the synchronised level disagrees with stable.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= din;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dout = stable_q;

endmodule

// File: rtl/irq_source.sv
// Button-driven interrupt request generator for the CP0 ir0..ir2 inputs:
// debounced press edges become sticky requests held until acknowledged.
module irq_source
   import irq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_IRQ-1:0]    btn,
   input  logic                ack,
   input  logic [IRQ_ID_W-1:0] ack_id,
   output logic [N_IRQ-1:0]    irq,
   output logic                req_valid,
   output logic [IRQ_ID_W-1:0] req_id,
   output logic [N_IRQ-1:0]    overrun,
   input  logic                overrun_clr
);

   logic [N_IRQ-1:0] stable;
   logic [N_IRQ-1:0] stable_q;
   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] ovr_q, ovr_d;

   for (genvar g = 0; g < int'(N_IRQ); g++) begin : g_db
      debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk  (clk),
         .rst  (rst),
         .din  (btn[g]),
         .dout (stable[g])
      );
   end

   assign rise = stable & ~stable_q;

   // ack_id == IRQ_ID_NONE never matches a channel index, so it is inert.
   always_comb begin
      pend_d = pend_q;
      ovr_d  = overrun_clr ? '0 : ovr_q;
      for (int unsigned n = 0; n < N_IRQ; n++) begin
         if (rise[n]) begin
            if (pend_q[n] && !(ack && ack_id == IRQ_ID_W'(n))) ovr_d[n] = 1'b1;
            pend_d[n] = 1'b1;
         end else if (ack && ack_id == IRQ_ID_W'(n)) begin
            pend_d[n] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_q <= '0;
         pend_q   <= '0;
         ovr_q    <= '0;
      end else begin
         stable_q <= stable;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
      end
   end

   assign irq       = pend_q;
   assign overrun   = ovr_q;
   assign req_valid = |pend_q;
   assign req_id    = prio_enc(pend_q);

endmodule

// File: tb/tb_irq_source.sv
// Directed bench for irq_source with DEBOUNCE_CYCLES=4: expectations are
// queued as stimulus is applied and popped at each checkpoint.
module tb_irq_source;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] btn;
   logic       ack;
   logic [1:0] ack_id;
   logic [2:0] irq;
   logic       req_valid;
   logic [1:0] req_id;
   logic [2:0] overrun;
   logic       overrun_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [2:0] irq;
      logic [2:0] ovr;
   } exp_t;

   exp_t sb[$];

   irq_source #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .ack         (ack),
      .ack_id      (ack_id),
      .irq         (irq),
      .req_valid   (req_valid),
      .req_id      (req_id),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] model_id(input logic [2:0] r);
      if (r[0]) return 2'd0;
      if (r[1]) return 2'd1;
      if (r[2]) return 2'd2;
      return 2'd0;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_state(input string tag, input logic [2:0] e_irq, input logic [2:0] e_ovr);
      exp_t e;
      e.tag = tag;
      e.irq = e_irq;
      e.ovr = e_ovr;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (irq === e.irq) else begin
            errors++;
            $error("FAIL %s irq: got %b expected %b", e.tag, irq, e.irq);
         end
         checks++;
         assert (req_valid === (|e.irq)) else begin
            errors++;
            $error("FAIL %s req_valid: got %b expected %b", e.tag, req_valid, |e.irq);
         end
         checks++;
         assert (req_id === model_id(e.irq)) else begin
            errors++;
            $error("FAIL %s req_id: got %0d expected %0d", e.tag, req_id, model_id(e.irq));
         end
         checks++;
         assert (overrun === e.ovr) else begin
            errors++;
            $error("FAIL %s overrun: got %b expected %b", e.tag, overrun, e.ovr);
         end
      end
   endtask

   task automatic do_ack(input logic [1:0] id);
      ack    = 1'b1;
      ack_id = id;
      tick(1);
      ack    = 1'b0;
      ack_id = 2'd0;
   endtask

   initial begin
      rst = 1'b1; btn = '0; ack = 1'b0; ack_id = '0; overrun_clr = 1'b0;
      tick(2);
      expect_state("reset", 3'b000, 3'b000);
      check_now();
      rst = 1'b0;

      // Clean press on channel 1, edge-exact latency.
      btn = 3'b010;
      tick(6);
      expect_state("press_edge6", 3'b000, 3'b000);
      check_now();
      tick(1);
      expect_state("press_edge7", 3'b010, 3'b000);
      check_now();
      tick(4);
      do_ack(2'd3);
      expect_state("ack_id3_ignored", 3'b010, 3'b000);
      check_now();
      do_ack(2'd0);
      expect_state("ack_not_pending", 3'b010, 3'b000);
      check_now();
      do_ack(2'd1);
      expect_state("ack_clears", 3'b000, 3'b000);
      check_now();
      btn = 3'b000;
      tick(10);

      // Glitch rejection then minimum-length pulse.
      btn = 3'b001;
      tick(3);
      btn = 3'b000;
      tick(20);
      expect_state("glitch3", 3'b000, 3'b000);
      check_now();
      btn = 3'b001;
      tick(4);
      btn = 3'b000;
      tick(6);
      expect_state("pulse4", 3'b001, 3'b000);
      check_now();
      do_ack(2'd0);
      tick(10);

      // Priority between channels 2 and 0.
      btn = 3'b101;
      tick(7);
      expect_state("prio_both", 3'b101, 3'b000);
      check_now();
      do_ack(2'd0);
      expect_state("prio_after_ack0", 3'b100, 3'b000);
      check_now();
      btn = 3'b000;
      tick(10);
      do_ack(2'd2);
      expect_state("prio_idle", 3'b000, 3'b000);
      check_now();

      // Overrun on channel 1, then clear.
      btn = 3'b010;
      tick(7);
      btn = 3'b000;
      tick(8);
      btn = 3'b010;
      tick(7);
      expect_state("overrun_set", 3'b010, 3'b010);
      check_now();
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      expect_state("overrun_clr", 3'b010, 3'b000);
      check_now();
      btn = 3'b000;
      tick(8);
      do_ack(2'd1);

      // Second press on channel 2 lands on the same edge as its ack.
      btn = 3'b100;
      tick(7);
      expect_state("sim_first", 3'b100, 3'b000);
      check_now();
      btn = 3'b000;
      tick(8);
      btn = 3'b100;
      tick(6);
      do_ack(2'd2);
      expect_state("sim_set_ack", 3'b100, 3'b000);
      check_now();
      btn = 3'b000;
      tick(8);
      do_ack(2'd2);

      // Asynchronous reset with two pending and channel 2 mid-count.
      btn = 3'b011;
      tick(7);
      expect_state("pre_reset", 3'b011, 3'b000);
      check_now();
      btn = 3'b111;
      tick(3);
      #3 rst = 1'b1;
      #1;
      expect_state("async_reset", 3'b000, 3'b000);
      check_now();
      btn = 3'b100;
      tick(2);
      rst = 1'b0;
      tick(6);
      expect_state("post_reset_edge6", 3'b000, 3'b000);
      check_now();
      tick(1);
      expect_state("post_reset_edge7", 3'b100, 3'b000);
      check_now();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
